// File: rtl/seg_pkg.sv
// Shared types and constants for the seg_scan_mux display scanner.
// Segment and anode values are active-low throughout.
package seg_pkg;

  typedef enum logic [1:0] {
    BLANK1_PRE = 2'd0,
    SHOW1      = 2'd1,
    BLANK0_PRE = 2'd2,
    SHOW0      = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_ONES  = 2'b10;

  function automatic logic is_blank(input scan_state_t s);
    return (s == BLANK1_PRE) || (s == BLANK0_PRE);
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-side bundle of seg_scan_mux: scan enable, two digit patterns in,
// shared segment bus, digit enables and frame marker out.
interface seg_scan_mux_if;

  logic       en;
  logic [6:0] d1;
  logic [6:0] d2;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_start;

  modport master (
    output en,
    output d1,
    output d2,
    input  seg,
    input  an,
    input  frame_start
  );

  modport slave (
    input  en,
    input  d1,
    input  d2,
    output seg,
    output an,
    output frame_start
  );

endinterface

// File: rtl/seg_scan_mux_timer.sv
// scan_timer: phase counter shared by SHOW and BLANK phases; len_sel picks
// which length sets the terminal count, load returns the count to zero.
module scan_timer #(
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic             len_sel,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // A zero blank length is never selected, so its terminal value defaults to zero and is unused.
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

  assign tc = (count == (len_sel ? BLANK_LAST : SHOW_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (step) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes two latched 7-segment digits onto one bus.
// Optional macro SEG_SCAN_LZB_EN darkens the tens slot when it shows a zero.
import seg_pkg::*;

module seg_scan_mux #(
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_mux_if.slave  bus
);

  // Without blanking the frame starts at SHOW1, which is also where scanning begins.
  localparam scan_state_t FRAME_STATE =
    scan_state_t'((BLANK_CYCLES == 0) ? SHOW1 : BLANK1_PRE);
  localparam bit HAS_BLANK = (BLANK_CYCLES != 0);

  scan_state_t      state_q;
  scan_state_t      state_d;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             step;
  logic             load;
  logic             len_sel;
  logic             boundary;
  logic [6:0]       lat_d1_q;
  logic [6:0]       lat_d2_q;
  logic [6:0]       lat_d1_d;
  logic [6:0]       lat_d2_d;
  logic [6:0]       seg_d;
  logic [6:0]       seg_q;
  logic [1:0]       an_d;
  logic [1:0]       an_q;
  logic             fs_d;
  logic             fs_q;

  scan_timer #(
    .SHOW_CYCLES  (SHOW_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .load    (load),
    .len_sel (len_sel),
    .count   (count),
    .tc      (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FRAME_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // The freshly latched pattern feeds the output path directly so that a
  // frame boundary landing in SHOW1 shows the new digit on its first cycle.
  always_comb begin
    state_d  = state_q;
    step     = bus.en;
    load     = 1'b0;
    len_sel  = is_blank(state_q);
    boundary = bus.en && (state_q == FRAME_STATE) && (count == '0);
    lat_d1_d = boundary ? bus.d1 : lat_d1_q;
    lat_d2_d = boundary ? bus.d2 : lat_d2_q;
    seg_d    = SEG_OFF;
    an_d     = AN_OFF;
    fs_d     = boundary;

    if (bus.en) begin
      if (tc) begin
        load = 1'b1;
        case (state_q)
          BLANK1_PRE: state_d = SHOW1;
          SHOW1: begin
            if (HAS_BLANK) state_d = BLANK0_PRE;
            else           state_d = SHOW0;
          end
          BLANK0_PRE: state_d = SHOW0;
          SHOW0: begin
            if (HAS_BLANK) state_d = BLANK1_PRE;
            else           state_d = SHOW1;
          end
          default: state_d = FRAME_STATE;
        endcase
      end

      case (state_q)
        SHOW1: begin
          an_d  = AN_TENS;
          seg_d = lat_d1_d;
`ifdef SEG_SCAN_LZB_EN
          if (lat_d1_d == SEG_ZERO) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
          end
`endif
        end
        SHOW0: begin
          an_d  = AN_ONES;
          seg_d = lat_d2_d;
        end
        default: begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
        end
      endcase
    end
  end

  // Pin registers reset asynchronously so a reset blanks the display at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_d1_q <= SEG_OFF;
      lat_d2_q <= SEG_OFF;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
      fs_q     <= 1'b0;
    end else begin
      lat_d1_q <= lat_d1_d;
      lat_d2_q <= lat_d2_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: two instances (with and without
// blanking) compared cycle by cycle against a frame-position reference model.
module tb_seg_scan_mux;

  localparam int S_A = 4;
  localparam int B_A = 2;
  localparam int S_B = 3;
  localparam int B_B = 0;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  int         pos_a;
  int         pos_b;
  logic [6:0] l1_a, l2_a, l1_b, l2_b;
  logic [1:0] ea;
  logic [6:0] es;
  logic       ef;

  logic [1:0] an_seq [12] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01,
                              2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};

  seg_scan_mux_if bus_a ();
  seg_scan_mux_if bus_b ();

  seg_scan_mux #(.SHOW_CYCLES(S_A), .BLANK_CYCLES(B_A), .CNT_W(4)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  seg_scan_mux #(.SHOW_CYCLES(S_B), .BLANK_CYCLES(B_B), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Reference: pos is the cycle index within the frame; blank, tens, blank,
  // ones slots follow from the lengths. Latches load at frame position 0.
  task automatic model_step(input int s_c, input int b_c, input logic en_v,
                            input logic [6:0] d1v, input logic [6:0] d2v,
                            inout int pos, inout logic [6:0] l1, inout logic [6:0] l2,
                            output logic [1:0] an_e, output logic [6:0] seg_e,
                            output logic fs_e);
    an_e  = 2'b11;
    seg_e = 7'h7F;
    fs_e  = 1'b0;
    if (en_v) begin
      if (pos == 0) begin
        l1   = d1v;
        l2   = d2v;
        fs_e = 1'b1;
      end
      if (pos >= b_c && pos < b_c + s_c) begin
        an_e  = 2'b01;
        seg_e = l1;
`ifdef SEG_SCAN_LZB_EN
        if (l1 == 7'b1000000) begin
          an_e  = 2'b11;
          seg_e = 7'h7F;
        end
`endif
      end else if (pos >= 2 * b_c + s_c) begin
        an_e  = 2'b10;
        seg_e = l2;
      end
      pos = (pos + 1) % (2 * (s_c + b_c));
    end
  endtask

  task automatic step_a();
    @(posedge clk);
    model_step(S_A, B_A, bus_a.en, bus_a.d1, bus_a.d2, pos_a, l1_a, l2_a, ea, es, ef);
    #1;
  endtask

  task automatic step_b();
    @(posedge clk);
    model_step(S_B, B_B, bus_b.en, bus_b.d1, bus_b.d2, pos_b, l1_b, l2_b, ea, es, ef);
    #1;
  endtask

  task automatic release_a();
    rst_a = 1'b0;
    pos_a = 0;
    l1_a  = 7'h7F;
    l2_a  = 7'h7F;
  endtask

  task automatic release_b();
    rst_b = 1'b0;
    pos_b = 0;
    l1_b  = 7'h7F;
    l2_b  = 7'h7F;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.en = 1'b1; bus_a.d1 = 7'h79; bus_a.d2 = 7'h24;
    bus_b.en = 1'b1; bus_b.d1 = 7'h79; bus_b.d2 = 7'h24;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_a.seg !== 7'h7F || bus_a.an !== 2'b11 || bus_a.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: seg=%h an=%b fs=%b expected seg=7f an=11 fs=0",
               bus_a.seg, bus_a.an, bus_a.frame_start);
    end
    checks++;
    if (bus_b.seg !== 7'h7F || bus_b.an !== 2'b11 || bus_b.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: seg=%h an=%b fs=%b expected seg=7f an=11 fs=0",
               bus_b.seg, bus_b.an, bus_b.frame_start);
    end
  endtask

  task automatic test_scan_pattern();
    release_a();
    for (int i = 0; i < 36; i++) begin
      step_a();
      checks++;
      if (bus_a.an !== ea || bus_a.seg !== es || bus_a.frame_start !== ef) begin
        failures++;
        $display("FAIL scan_model cyc%0d: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                 i, bus_a.an, bus_a.seg, bus_a.frame_start, ea, es, ef);
      end
      checks++;
      if (bus_a.an !== an_seq[i % 12] || bus_a.frame_start !== (i % 12 == 0)) begin
        failures++;
        $display("FAIL scan_table cyc%0d: an=%b fs=%b expected an=%b fs=%b",
                 i, bus_a.an, bus_a.frame_start, an_seq[i % 12], (i % 12 == 0));
      end
    end
  endtask

  task automatic test_input_latch();
    bit changed = 1'b0;
    bit seen_fs = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!changed && pos_a == B_A + 1) begin
        bus_a.d2 = 7'h30;
        changed  = 1'b1;
      end
      step_a();
      checks++;
      if (bus_a.an !== ea || bus_a.seg !== es || bus_a.frame_start !== ef) begin
        failures++;
        $display("FAIL latch_model cyc%0d: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                 i, bus_a.an, bus_a.seg, bus_a.frame_start, ea, es, ef);
      end
      if (changed && bus_a.frame_start === 1'b1) seen_fs = 1'b1;
      if (changed && bus_a.an === 2'b10) begin
        checks++;
        if (bus_a.seg !== (seen_fs ? 7'h30 : 7'h24)) begin
          failures++;
          $display("FAIL latch_hold cyc%0d: seg=%h expected %h",
                   i, bus_a.seg, (seen_fs ? 7'h30 : 7'h24));
        end
      end
    end
  endtask

  task automatic test_enable_freeze();
    int first_i = -1;
    int gap     = -1;
    int frozen  = 0;
    for (int i = 0; i < 12 && pos_a != 0; i++) begin
      step_a();
      checks++;
      if (bus_a.an !== ea || bus_a.seg !== es) begin
        failures++;
        $display("FAIL freeze_align: an=%b seg=%h expected an=%b seg=%h", bus_a.an, bus_a.seg, ea, es);
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (pos_a == 2 * B_A + S_A + 1 && frozen < 5) begin
        bus_a.en = 1'b0;
        frozen++;
      end else begin
        bus_a.en = 1'b1;
      end
      step_a();
      checks++;
      if (bus_a.an !== ea || bus_a.seg !== es || bus_a.frame_start !== ef) begin
        failures++;
        $display("FAIL freeze_model cyc%0d: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                 i, bus_a.an, bus_a.seg, bus_a.frame_start, ea, es, ef);
      end
      if (bus_a.frame_start === 1'b1) begin
        if (first_i < 0) begin
          first_i = i;
        end else begin
          gap = i - first_i;
          break;
        end
      end
    end
    bus_a.en = 1'b1;
    checks++;
    if (gap !== 17) begin
      failures++;
      $display("FAIL freeze_frame_len: got %0d expected 17", gap);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 14 && pos_a != B_A + 2; i++) begin
      step_a();
      checks++;
      if (bus_a.an !== ea || bus_a.seg !== es) begin
        failures++;
        $display("FAIL areset_align: an=%b seg=%h expected an=%b seg=%h", bus_a.an, bus_a.seg, ea, es);
      end
    end
    step_a();
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if (bus_a.seg !== 7'h7F || bus_a.an !== 2'b11 || bus_a.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: seg=%h an=%b fs=%b expected seg=7f an=11 fs=0",
               bus_a.seg, bus_a.an, bus_a.frame_start);
    end
    bus_a.d1 = 7'h12;
    bus_a.d2 = 7'h02;
    repeat (2) @(posedge clk);
    #1;
    release_a();
    for (int i = 0; i < 14; i++) begin
      step_a();
      checks++;
      if (bus_a.an !== ea || bus_a.seg !== es || bus_a.frame_start !== ef) begin
        failures++;
        $display("FAIL areset_restart cyc%0d: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                 i, bus_a.an, bus_a.seg, bus_a.frame_start, ea, es, ef);
      end
    end
  endtask

  task automatic test_leading_zero();
    bus_a.d1 = 7'b1000000;
    bus_a.d2 = 7'h24;
    for (int i = 0; i < 26; i++) begin
      if (i == 13) bus_a.d1 = 7'h79;
      step_a();
      checks++;
      if (bus_a.an !== ea || bus_a.seg !== es || bus_a.frame_start !== ef) begin
        failures++;
        $display("FAIL lzb cyc%0d: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                 i, bus_a.an, bus_a.seg, bus_a.frame_start, ea, es, ef);
      end
    end
  endtask

  task automatic test_no_blank();
    rst_a = 1'b1;
    bus_b.en = 1'b1;
    bus_b.d1 = 7'(($urandom_range(0, 127)));
    bus_b.d2 = 7'(($urandom_range(0, 127)));
    release_b();
    for (int i = 0; i < 24; i++) begin
      step_b();
      checks++;
      if (bus_b.an !== ea || bus_b.seg !== es || bus_b.frame_start !== ef || bus_b.an === 2'b00) begin
        failures++;
        $display("FAIL no_blank cyc%0d: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                 i, bus_b.an, bus_b.seg, bus_b.frame_start, ea, es, ef);
      end
    end
  endtask

  task automatic test_random_b();
    for (int i = 0; i < 200; i++) begin
      bus_b.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) bus_b.d1 = 7'(($urandom_range(0, 127)));
      if ($urandom_range(0, 2) == 0) bus_b.d2 = 7'(($urandom_range(0, 127)));
      if ($urandom_range(0, 5) == 0) bus_b.d1 = 7'b1000000;
      step_b();
      checks++;
      if (bus_b.an !== ea || bus_b.seg !== es || bus_b.frame_start !== ef || bus_b.an === 2'b00) begin
        failures++;
        $display("FAIL random_b cyc%0d: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                 i, bus_b.an, bus_b.seg, bus_b.frame_start, ea, es, ef);
      end
    end
    rst_b = 1'b1;
  endtask

  task automatic test_random_a();
    bus_a.en = 1'b1;
    release_a();
    for (int i = 0; i < 300; i++) begin
      bus_a.en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) bus_a.d1 = 7'(($urandom_range(0, 127)));
      if ($urandom_range(0, 2) == 0) bus_a.d2 = 7'(($urandom_range(0, 127)));
      if ($urandom_range(0, 5) == 0) bus_a.d1 = 7'b1000000;
      step_a();
      checks++;
      if (bus_a.an !== ea || bus_a.seg !== es || bus_a.frame_start !== ef || bus_a.an === 2'b00) begin
        failures++;
        $display("FAIL random_a cyc%0d: an=%b seg=%h fs=%b expected an=%b seg=%h fs=%b",
                 i, bus_a.an, bus_a.seg, bus_a.frame_start, ea, es, ef);
      end
    end
  endtask

  initial begin
    $display("[TB] seg_scan_mux bench start");
    test_reset();
    test_scan_pattern();
    test_input_latch();
    test_enable_freeze();
    test_async_reset();
    test_leading_zero();
    test_no_blank();
    test_random_b();
    test_random_a();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
